bram_port_arbiter: RTL and testbench

Arbitrates port B of the CPU's 64 KB dual-port block RAM among up to N requesters: CPU data access, DMA engine, video fetch. It sequences every access through a fixed state machine, registers all BRAM-side signals, and returns read data with a one-cycle acknowledge. Locked bursts let one requester keep ownership, bounded by a starvation limit. Port A (instruction fetch at PC) is not affected.

---
 rtl/bram_arb_pkg.sv | 44 ++++
 rtl/bram_port_arbiter_rr_picker.sv | 35 +++
 rtl/bram_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_bram_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types and constants for the BRAM port-B arbiter.
//   arb_state_e - arbiter sequencing states.
//   DEF_*       - default parameter values for bram_port_arbiter.
//   get_lane    - pulls one fixed-width lane out of a packed per-requester bus.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2,
    ST_ACK    = 2'd3
  } arb_state_e;

  localparam int DEF_N_REQ    = 3;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_PRIO0    = 1;
  localparam int DEF_LOCK_MAX = 8;

  // get_lane works on a zero-extended copy of the packed bus so one function
  // serves both the address and write-data buses.
  localparam int LANE_MAX  = 32;
  localparam int BUS_MAX   = 512;
  localparam int BUS_POS_W = 9;

  function automatic logic [LANE_MAX-1:0] get_lane(
    input logic [BUS_MAX-1:0] bus,
    input int                 idx,
    input int                 width
  );
    logic [LANE_MAX-1:0] lane;
    int                  pos;
    lane = '0;
    pos  = 0;
    for (int b = 0; b < LANE_MAX; b++) begin
      pos = idx * width + b;
      if ((b < width) && (pos < BUS_MAX)) begin
        lane[b] = bus[BUS_POS_W'(pos)];
      end
    end
    return lane;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search.
//   req     - request vector
//   rr_last - index of the most recent grant; search starts just after it
//   excl    - requesters to ignore in this search
//   win     - first eligible requester found
//   vld     - a winner exists
module rr_picker
  import bram_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_last,
  input  logic [N_REQ-1:0] excl,
  output logic [IDX_W-1:0] win,
  output logic             vld
);

  always_comb begin
    int k;
    k   = 0;
    win = '0;
    vld = 1'b0;
    // i runs 1..N_REQ so the last-granted requester is tried last.
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(rr_last) + i) % N_REQ;
      if (!vld && req[IDX_W'(k)] && !excl[IDX_W'(k)]) begin
        vld = 1'b1;
        win = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares BRAM port B among N_REQ requesters (0 = video).
// Every access runs IDLE -> ACCESS -> (RDATA) -> ACK; all BRAM-side signals
// are registered and the owner receives a one-cycle o_ack.
//
//   state  | meaning
//   IDLE   | arbitrate; on a winner latch address/we/data, record owner
//   ACCESS | BRAM samples port B at the end of this cycle; we dropped
//   RDATA  | capture i_bram_do into o_rdata (reads only)
//   ACK    | o_ack[owner] pulse; decide whether the lock is held
//
// Ports:
//   i_clk, i_rst (async, active low)
//   i_req/i_we/i_lock [N_REQ]      per-requester controls
//   i_addr [N_REQ*ADDR_W], i_wdata [N_REQ*DATA_W]  packed lanes
//   o_ack [N_REQ], o_rdata, o_grant [N_REQ], o_busy
//   o_bram_we, o_bram_addr, o_bram_di, i_bram_do   BRAM port B
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PRIO0    = DEF_PRIO0,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_we,
  input  logic [N_REQ-1:0]          i_lock,
  input  logic [N_REQ*ADDR_W-1:0]   i_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_wdata,
  output logic [N_REQ-1:0]          o_ack,
  output logic [DATA_W-1:0]         o_rdata,
  output logic [N_REQ-1:0]          o_grant,
  output logic                      o_busy,
  output logic                      o_bram_we,
  output logic [ADDR_W-1:0]         o_bram_addr,
  output logic [DATA_W-1:0]         o_bram_di,
  input  logic [DATA_W-1:0]         i_bram_do
);

  localparam int         IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  arb_state_e        state, state_nx;
  logic [IDX_W-1:0]  owner, rr_last, win, pk_win;
  logic              win_vld, pk_vld;
  logic [7:0]        lock_cnt;
  logic              lock_held;
  logic              excl_prev;
  logic [N_REQ-1:0]  owner_oh, excl_mask;

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  // After a burst hits LOCK_MAX the previous owner sits out one arbitration.
  assign excl_mask = excl_prev ? owner_oh : '0;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (i_req),
    .rr_last (rr_last),
    .excl    (excl_mask),
    .win     (pk_win),
    .vld     (pk_vld)
  );

  // A held lock blocks everyone else, requester 0 included.
  always_comb begin
    win     = pk_win;
    win_vld = pk_vld;
    if (lock_held) begin
      win     = owner;
      win_vld = i_req[owner];
    end else if ((PRIO0 != 0) && i_req[0] && !excl_mask[0]) begin
      win     = '0;
      win_vld = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (win_vld) state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = o_bram_we ? ST_ACK : ST_RDATA;
      ST_RDATA:  state_nx = ST_ACK;
      ST_ACK:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (state != ST_IDLE);
    o_grant = (state != ST_IDLE) ? owner_oh : '0;
    o_ack   = (state == ST_ACK)  ? owner_oh : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      owner       <= '0;
      rr_last     <= IDX_W'(N_REQ - 1);
      lock_cnt    <= 8'd0;
      lock_held   <= 1'b0;
      excl_prev   <= 1'b0;
      o_bram_we   <= 1'b0;
      o_bram_addr <= '0;
      o_bram_di   <= '0;
      o_rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          excl_prev <= 1'b0;
          if (win_vld) begin
            owner       <= win;
            rr_last     <= win;
            o_bram_we   <= i_we[win];
            o_bram_addr <= ADDR_W'(get_lane(BUS_MAX'(i_addr), int'(win), ADDR_W));
            o_bram_di   <= DATA_W'(get_lane(BUS_MAX'(i_wdata), int'(win), DATA_W));
            // Only grants made under a held lock extend the burst count.
            lock_cnt    <= lock_held ? (lock_cnt + 8'd1) : 8'd0;
          end
        end
        ST_ACCESS: o_bram_we <= 1'b0;
        ST_RDATA:  o_rdata   <= i_bram_do;
        ST_ACK: begin
          lock_held <= i_lock[owner] && (lock_cnt < LOCK_LIM);
          excl_prev <= (lock_cnt >= LOCK_LIM);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

  logic clk;
  logic rst_n;

  // dut_a: round-robin (PRIO0=0), LOCK_MAX=2
  logic [2:0]  req_a, we_a, lock_a, ack_a, grant_a;
  logic [47:0] addr_a;
  logic [23:0] wdata_a;
  logic [7:0]  rdata_a, bdi_a, bdo_a;
  logic [15:0] baddr_a;
  logic        busy_a, bwe_a;

  // dut_b: requester-0 priority (PRIO0=1)
  logic [2:0]  req_b, we_b, lock_b, ack_b, grant_b;
  logic [47:0] addr_b;
  logic [23:0] wdata_b;
  logic [7:0]  rdata_b, bdi_b, bdo_b;
  logic [15:0] baddr_b;
  logic        busy_b, bwe_b;

  logic [7:0]  mem_a [0:65535];
  logic [7:0]  mem_b [0:65535];
  logic        pre_en;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  logic [2:0]  lk_exp [0:4];
  int n_pass;
  int n_chk;

  bram_port_arbiter #(.N_REQ(3), .ADDR_W(16), .DATA_W(8), .PRIO0(0), .LOCK_MAX(2)) dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_req(req_a), .i_we(we_a), .i_lock(lock_a),
    .i_addr(addr_a), .i_wdata(wdata_a), .o_ack(ack_a), .o_rdata(rdata_a),
    .o_grant(grant_a), .o_busy(busy_a), .o_bram_we(bwe_a), .o_bram_addr(baddr_a),
    .o_bram_di(bdi_a), .i_bram_do(bdo_a)
  );

  bram_port_arbiter #(.N_REQ(3), .ADDR_W(16), .DATA_W(8), .PRIO0(1), .LOCK_MAX(8)) dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_req(req_b), .i_we(we_b), .i_lock(lock_b),
    .i_addr(addr_b), .i_wdata(wdata_b), .o_ack(ack_b), .o_rdata(rdata_b),
    .o_grant(grant_b), .o_busy(busy_b), .o_bram_we(bwe_b), .o_bram_addr(baddr_b),
    .o_bram_di(bdi_b), .i_bram_do(bdo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read-first BRAM models for port B.
  always @(posedge clk) begin
    if (pre_en)     mem_a[pre_addr] <= pre_data;
    else if (bwe_a) mem_a[baddr_a]  <= bdi_a;
    bdo_a <= mem_a[baddr_a];
  end

  always @(posedge clk) begin
    if (bwe_b) mem_b[baddr_b] <= bdi_b;
    bdo_b <= mem_b[baddr_b];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    rst_n  = 1'b0;
    req_a = '0; we_a = '0; lock_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; lock_b = '0; addr_b = '0; wdata_b = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    lk_exp[0] = 3'b010; lk_exp[1] = 3'b010; lk_exp[2] = 3'b010;
    lk_exp[3] = 3'b100; lk_exp[4] = 3'b010;

    tick; tick;
    pre_en = 1'b1; pre_addr = 16'h1234; pre_data = 8'hA5;
    tick;
    pre_en = 1'b0;

    chk("rst_ack",   32'(ack_a),   32'h0);
    chk("rst_grant", 32'(grant_a), 32'h0);
    chk("rst_busy",  32'(busy_a),  32'h0);
    chk("rst_we",    32'(bwe_a),   32'h0);
    chk("rst_addr",  32'(baddr_a), 32'h0);
    chk("rst_di",    32'(bdi_a),   32'h0);
    chk("rst_rdata", 32'(rdata_a), 32'h0);

    rst_n = 1'b1;
    tick;

    // Single read: requester 1 reads 0x1234.
    req_a = 3'b010; we_a = 3'b000; addr_a = {16'h0000, 16'h1234, 16'h0000};
    tick;
    chk("rd_c1_addr",  32'(baddr_a), 32'h1234);
    chk("rd_c1_we",    32'(bwe_a),   32'h0);
    chk("rd_c1_grant", 32'(grant_a), 32'h2);
    chk("rd_c1_busy",  32'(busy_a),  32'h1);
    chk("rd_c1_ack",   32'(ack_a),   32'h0);
    tick;
    chk("rd_c2_ack",   32'(ack_a),   32'h0);
    tick;
    chk("rd_c3_ack",   32'(ack_a),   32'h2);
    chk("rd_c3_rdata", 32'(rdata_a), 32'hA5);
    req_a = 3'b000;
    tick;
    chk("rd_idle_ack",   32'(ack_a),   32'h0);
    chk("rd_idle_busy",  32'(busy_a),  32'h0);
    chk("rd_idle_grant", 32'(grant_a), 32'h0);

    // Single write: requester 2 writes 0x5A to 0x00FF.
    req_a = 3'b100; we_a = 3'b100;
    addr_a = {16'h00FF, 32'h0}; wdata_a = {8'h5A, 16'h0000};
    tick;
    chk("wr_c1_we",    32'(bwe_a),   32'h1);
    chk("wr_c1_addr",  32'(baddr_a), 32'h00FF);
    chk("wr_c1_di",    32'(bdi_a),   32'h5A);
    chk("wr_c1_grant", 32'(grant_a), 32'h4);
    tick;
    chk("wr_c2_ack",   32'(ack_a),   32'h4);
    chk("wr_c2_we",    32'(bwe_a),   32'h0);
    req_a = 3'b000; we_a = 3'b000;
    tick;
    chk("wr_idle_busy", 32'(busy_a), 32'h0);

    // Read back 0x00FF through requester 0.
    req_a = 3'b001; addr_a = {32'h0, 16'h00FF}; wdata_a = '0;
    tick; tick; tick;
    chk("rb_ack",   32'(ack_a),   32'h1);
    chk("rb_rdata", 32'(rdata_a), 32'h5A);
    req_a = 3'b000;
    tick;

    // Reset asserted while in RDATA.
    req_a = 3'b010; addr_a = {16'h0000, 16'h1234, 16'h0000};
    tick; tick;
    chk("mr_busy_pre", 32'(busy_a), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_ack",   32'(ack_a),   32'h0);
    chk("mr_grant", 32'(grant_a), 32'h0);
    chk("mr_busy",  32'(busy_a),  32'h0);
    chk("mr_we",    32'(bwe_a),   32'h0);
    chk("mr_addr",  32'(baddr_a), 32'h0);
    chk("mr_rdata", 32'(rdata_a), 32'h0);
    req_a = 3'b000;
    tick; tick;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("mr_no_ack", 32'(ack_a), 32'h0);
    end
    req_a = 3'b010;
    tick;
    chk("mr_fresh_addr", 32'(baddr_a), 32'h1234);
    tick; tick;
    chk("mr_fresh_ack",   32'(ack_a),   32'h2);
    chk("mr_fresh_rdata", 32'(rdata_a), 32'hA5);
    req_a = 3'b000;
    tick;

    // Round-robin from a fresh reset: all three hold write requests.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    req_a = 3'b111; we_a = 3'b111;
    addr_a = {16'h0102, 16'h0101, 16'h0100}; wdata_a = {8'h12, 8'h11, 8'h10};
    for (int g = 0; g < 6; g++) begin
      tick;
      chk("rr_grant", 32'(grant_a), 32'(3'b001 << (g % 3)));
      chk("rr_addr",  32'(baddr_a), 32'(16'h0100 + 16'(g % 3)));
      tick;
      chk("rr_ack",   32'(ack_a),   32'(3'b001 << (g % 3)));
      if (g == 5) begin
        req_a = 3'b000; we_a = 3'b000;
      end
      tick;
    end

    // Lock limit: requester 1 bursts with lock while requester 2 waits.
    req_a = 3'b110; we_a = 3'b110; lock_a = 3'b010;
    addr_a = {16'h0202, 16'h0201, 16'h0000}; wdata_a = {8'h22, 8'h21, 8'h00};
    for (int g = 0; g < 5; g++) begin
      tick;
      chk("lk_grant", 32'(grant_a), 32'(lk_exp[g]));
      tick;
      chk("lk_ack", 32'(ack_a), 32'(lk_exp[g]));
      if (lk_exp[g] == 3'b100) begin
        req_a = 3'b010; we_a = 3'b010;
      end
      if (g == 4) begin
        req_a = 3'b000; we_a = 3'b000; lock_a = 3'b000;
      end
      tick;
    end
    chk("lk_idle_busy", 32'(busy_a), 32'h0);

    // Priority: requester 0 served alone first so round-robin would favour 1.
    req_b = 3'b001; we_b = 3'b001; addr_b = {32'h0, 16'h0300}; wdata_b = {16'h0, 8'h30};
    tick;
    chk("pr_solo_grant", 32'(grant_b), 32'h1);
    tick;
    chk("pr_solo_ack", 32'(ack_b), 32'h1);
    req_b = 3'b000; we_b = 3'b000;
    tick;
    req_b = 3'b011; we_b = 3'b011;
    addr_b = {16'h0000, 16'h0311, 16'h0310}; wdata_b = {8'h00, 8'h31, 8'h30};
    tick;
    chk("pr_first_grant", 32'(grant_b), 32'h1);
    tick;
    chk("pr_first_ack", 32'(ack_b), 32'h1);
    req_b = 3'b010; we_b = 3'b010;
    tick;
    tick;
    chk("pr_second_grant", 32'(grant_b), 32'h2);
    chk("pr_second_addr",  32'(baddr_b), 32'h0311);
    tick;
    chk("pr_second_ack", 32'(ack_b), 32'h2);
    req_b = 3'b000; we_b = 3'b000;
    tick;
    chk("pr_idle_busy", 32'(busy_b), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
